// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction register and instruction-memory fetch handshake
//
// Optional feature: define FETCH_BOUNDS_CHECK_EN to enable PC bounds checking
// against PC_LIMIT (out-of-range updates are dropped and raise a sticky Fault).
//
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous active-low reset
//   PCReset      synchronous active-low, PC <= RESET_PC
//   PCWrite      PC <= PCTarget
//   PCTarget     absolute jump target
//   PCIncrement  PC <= PC + sign-extended PCImmediate
//   PCImmediate  signed 8-bit displacement
//   IRWrite      fetch request at current PC
//   IRReset      synchronous active-low, clears INS and aborts fetch
//   MemReq       memory read request
//   MemAddr      latched read address
//   MemReady     memory data valid
//   MemData      memory read data
//   INS          instruction register
//   PC           program counter
//   FetchBusy    fetch in flight
//   Fault        sticky bounds fault (0 when bounds checking is compiled out)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LIMIT = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCReset,
    input  logic        PCWrite,
    input  logic [15:0] PCTarget,
    input  logic        PCIncrement,
    input  logic [7:0]  PCImmediate,
    input  logic        IRWrite,
    input  logic        IRReset,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    input  logic        MemReady,
    input  logic [15:0] MemData,
    output logic [15:0] INS,
    output logic [15:0] PC,
    output logic        FetchBusy,
    output logic        Fault
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state;
    logic        pc_update;
    logic [15:0] pc_next;
    logic        pc_out_of_range;
    logic        fetch_allowed;

    // Candidate PC from write/increment; PCReset is handled in the register itself.
    always_comb begin
        pc_update = 1'b0;
        pc_next   = PC;
        if (PCWrite) begin
            pc_update = 1'b1;
            pc_next   = PCTarget;
        end else if (PCIncrement) begin
            pc_update = 1'b1;
            pc_next   = PC + {{8{PCImmediate[7]}}, PCImmediate};
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    // Increments are compared after 16-bit wrap, so a wrap to a low address is legal.
    assign pc_out_of_range = pc_update && (pc_next > PC_LIMIT);
    assign fetch_allowed   = !Fault;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Fault <= 1'b0;
        end else if (!PCReset) begin
            Fault <= 1'b0;
        end else if (pc_out_of_range) begin
            Fault <= 1'b1;
        end
    end
`else
    logic unused_pc_limit;
    assign unused_pc_limit = ^PC_LIMIT;
    assign pc_out_of_range = 1'b0;
    assign fetch_allowed   = 1'b1;
    assign Fault           = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            PC <= RESET_PC;
        end else if (!PCReset) begin
            PC <= RESET_PC;
        end else if (pc_update && !pc_out_of_range) begin
            PC <= pc_next;
        end
    end

    // Fetch FSM. MemAddr captures the pre-update PC so a PC change issued in the
    // same cycle, or while waiting, never redirects the fetch in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            MemReq    <= 1'b0;
            FetchBusy <= 1'b0;
            MemAddr   <= 16'h0000;
            INS       <= 16'h0000;
        end else if (!IRReset) begin
            state     <= IDLE;
            MemReq    <= 1'b0;
            FetchBusy <= 1'b0;
            INS       <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (IRWrite && fetch_allowed) begin
                        state     <= REQ;
                        MemReq    <= 1'b1;
                        FetchBusy <= 1'b1;
                        MemAddr   <= PC;
                    end
                end
                REQ: begin
                    if (MemReady) begin
                        state     <= IDLE;
                        MemReq    <= 1'b0;
                        FetchBusy <= 1'b0;
                        INS       <= MemData;
                    end
                end
                default: begin
                    state     <= IDLE;
                    MemReq    <= 1'b0;
                    FetchBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural reference model
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] LIMIT  = 16'h00FF;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic        PCReset;
    logic        PCWrite;
    logic [15:0] PCTarget;
    logic        PCIncrement;
    logic [7:0]  PCImmediate;
    logic        IRWrite;
    logic        IRReset;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemReady;
    logic [15:0] MemData;
    logic [15:0] INS;
    logic [15:0] PC;
    logic        FetchBusy;
    logic        Fault;

    int vectors;
    int miscompares;

    // Reference model state: program counter, instruction, fetch-in-flight flag,
    // latched fetch address, sticky fault.
    int m_pc;
    int m_ins;
    bit m_busy;
    int m_addr;
    bit m_fault;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .PC_LIMIT(LIMIT)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PCReset    (PCReset),
        .PCWrite    (PCWrite),
        .PCTarget   (PCTarget),
        .PCIncrement(PCIncrement),
        .PCImmediate(PCImmediate),
        .IRWrite    (IRWrite),
        .IRReset    (IRReset),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemReady   (MemReady),
        .MemData    (MemData),
        .INS        (INS),
        .PC         (PC),
        .FetchBusy  (FetchBusy),
        .Fault      (Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic model_reset();
        m_pc    = int'(RST_PC);
        m_ins   = 0;
        m_busy  = 1'b0;
        m_addr  = 0;
        m_fault = 1'b0;
    endtask

    // One clock of behaviour, from the rules: fetch side sees the old PC and old fault.
    task automatic model_clock();
        int nxt;
        bit upd;
        if (!IRReset) begin
            m_ins  = 0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (MemReady) begin
                m_ins  = int'(MemData);
                m_busy = 1'b0;
            end
        end else if (IRWrite && !m_fault) begin
            m_addr = m_pc;
            m_busy = 1'b1;
        end
        if (!PCReset) begin
            m_pc    = int'(RST_PC);
            m_fault = 1'b0;
        end else begin
            upd = 1'b1;
            nxt = m_pc;
            if (PCWrite) nxt = int'(PCTarget);
            else if (PCIncrement) nxt = (m_pc + int'($signed(PCImmediate)) + 65536) % 65536;
            else upd = 1'b0;
            if (upd) begin
                if (BOUNDS && nxt > int'(LIMIT)) m_fault = 1'b1;
                else m_pc = nxt;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        PCReset     = 1'b1;
        PCWrite     = 1'b0;
        PCTarget    = 16'h0000;
        PCIncrement = 1'b0;
        PCImmediate = 8'h00;
        IRWrite     = 1'b0;
        IRReset     = 1'b1;
        MemReady    = 1'b0;
        MemData     = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b0;
        #12;
        vectors += 6;
        if (PC !== RST_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", PC, RST_PC); end
        if (INS !== 16'h0000) begin miscompares++; $display("FAIL reset_ins: got %h expected 0000", INS); end
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL reset_memreq: got %b expected 0", MemReq); end
        if (MemAddr !== 16'h0000) begin miscompares++; $display("FAIL reset_memaddr: got %h expected 0000", MemAddr); end
        if (FetchBusy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", FetchBusy); end
        if (Fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", Fault); end
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic test_first_fetch();
        idle_inputs();
        IRWrite = 1'b1;
        tick();
        IRWrite  = 1'b0;
        MemReady = 1'b1;
        MemData  = 16'h0512;
        vectors += 3;
        if (MemReq !== 1'b1) begin miscompares++; $display("FAIL first_memreq: got %b expected 1", MemReq); end
        if (MemAddr !== 16'h0000) begin miscompares++; $display("FAIL first_memaddr: got %h expected 0000", MemAddr); end
        if (FetchBusy !== 1'b1) begin miscompares++; $display("FAIL first_busy: got %b expected 1", FetchBusy); end
        tick();
        idle_inputs();
        vectors += 3;
        if (INS !== 16'h0512) begin miscompares++; $display("FAIL first_ins: got %h expected 0512", INS); end
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL first_memreq_drop: got %b expected 0", MemReq); end
        if (FetchBusy !== 1'b0) begin miscompares++; $display("FAIL first_busy_drop: got %b expected 0", FetchBusy); end
    endtask

    task automatic test_increment();
        idle_inputs();
        PCWrite = 1'b1; PCTarget = 16'h0010;
        tick();
        idle_inputs();
        PCIncrement = 1'b1; PCImmediate = 8'hFE;
        tick();
        vectors++;
        if (PC !== 16'h000E) begin miscompares++; $display("FAIL inc_neg: got %h expected 000E", PC); end
        PCImmediate = 8'h7F;
        tick();
        vectors++;
        if (PC !== 16'h008D) begin miscompares++; $display("FAIL inc_pos: got %h expected 008D", PC); end
`ifndef FETCH_BOUNDS_CHECK_EN
        idle_inputs();
        PCWrite = 1'b1; PCTarget = 16'hFFFF;
        tick();
        idle_inputs();
        PCIncrement = 1'b1; PCImmediate = 8'h01;
        tick();
        vectors++;
        if (PC !== 16'h0000) begin miscompares++; $display("FAIL inc_wrap: got %h expected 0000", PC); end
        PCImmediate = 8'hFF;
        tick();
        vectors++;
        if (PC !== 16'hFFFF) begin miscompares++; $display("FAIL dec_wrap: got %h expected FFFF", PC); end
`endif
        idle_inputs();
    endtask

    task automatic test_jump_during_fetch();
        logic [15:0] jt;
        jt = BOUNDS ? 16'h00F0 : 16'h0100;
        idle_inputs();
        PCWrite = 1'b1; PCTarget = 16'h0020;
        tick();
        idle_inputs();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        PCWrite = 1'b1; PCTarget = jt;
        for (int i = 0; i < 3; i++) begin
            tick();
            PCWrite = 1'b0;
            vectors += 2;
            if (MemAddr !== 16'h0020) begin miscompares++; $display("FAIL jump_memaddr[%0d]: got %h expected 0020", i, MemAddr); end
            if (MemReq !== 1'b1) begin miscompares++; $display("FAIL jump_memreq[%0d]: got %b expected 1", i, MemReq); end
        end
        MemReady = 1'b1; MemData = 16'h1234;
        tick();
        idle_inputs();
        vectors += 3;
        if (PC !== jt) begin miscompares++; $display("FAIL jump_pc: got %h expected %h", PC, jt); end
        if (INS !== 16'h1234) begin miscompares++; $display("FAIL jump_ins: got %h expected 1234", INS); end
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL jump_done: got %b expected 0", MemReq); end
    endtask

    task automatic test_irreset_priority();
        idle_inputs();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        IRReset = 1'b0; MemReady = 1'b1; MemData = 16'hBEEF;
        tick();
        idle_inputs();
        vectors += 3;
        if (INS !== 16'h0000) begin miscompares++; $display("FAIL irreset_ins: got %h expected 0000", INS); end
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL irreset_memreq: got %b expected 0", MemReq); end
        if (FetchBusy !== 1'b0) begin miscompares++; $display("FAIL irreset_busy: got %b expected 0", FetchBusy); end
        // IRWrite together with IRReset must not start a fetch
        IRWrite = 1'b1; IRReset = 1'b0;
        tick();
        idle_inputs();
        vectors++;
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL irreset_blocks_fetch: got %b expected 0", MemReq); end
    endtask

    task automatic test_pc_priority();
        idle_inputs();
        PCWrite = 1'b1; PCTarget = 16'h0044;
        tick();
        PCReset = 1'b0; PCIncrement = 1'b1; PCImmediate = 8'h05; PCTarget = 16'h0077;
        tick();
        vectors++;
        if (PC !== RST_PC) begin miscompares++; $display("FAIL prio_pcreset: got %h expected %h", PC, RST_PC); end
        PCReset = 1'b1;
        tick();
        idle_inputs();
        vectors++;
        if (PC !== 16'h0077) begin miscompares++; $display("FAIL prio_write: got %h expected 0077", PC); end
    endtask

    task automatic test_bounds();
        idle_inputs();
        PCWrite = 1'b1; PCTarget = 16'h0030;
        tick();
        PCTarget = 16'h0100;
        tick();
        idle_inputs();
`ifdef FETCH_BOUNDS_CHECK_EN
        vectors += 2;
        if (PC !== 16'h0030) begin miscompares++; $display("FAIL bounds_pc_hold: got %h expected 0030", PC); end
        if (Fault !== 1'b1) begin miscompares++; $display("FAIL bounds_fault: got %b expected 1", Fault); end
        IRWrite = 1'b1;
        tick();
        idle_inputs();
        vectors++;
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL bounds_no_fetch: got %b expected 0", MemReq); end
        PCReset = 1'b0;
        tick();
        idle_inputs();
        vectors++;
        if (Fault !== 1'b0) begin miscompares++; $display("FAIL bounds_clear: got %b expected 0", Fault); end
`else
        vectors += 2;
        if (PC !== 16'h0100) begin miscompares++; $display("FAIL nobounds_pc: got %h expected 0100", PC); end
        if (Fault !== 1'b0) begin miscompares++; $display("FAIL nobounds_fault: got %b expected 0", Fault); end
`endif
    endtask

    task automatic test_async_reset();
        idle_inputs();
        PCWrite = 1'b1; PCTarget = 16'h0055;
        tick();
        idle_inputs();
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        vectors++;
        if (MemReq !== 1'b1) begin miscompares++; $display("FAIL async_pre_memreq: got %b expected 1", MemReq); end
        #2 Reset = 1'b0;
        #1;
        vectors += 3;
        if (MemReq !== 1'b0) begin miscompares++; $display("FAIL async_memreq: got %b expected 0", MemReq); end
        if (FetchBusy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b expected 0", FetchBusy); end
        if (PC !== RST_PC) begin miscompares++; $display("FAIL async_pc: got %h expected %h", PC, RST_PC); end
        model_reset();
        Reset = 1'b1;
        MemReady = 1'b1; MemData = 16'hAAAA;
        tick();
        idle_inputs();
        vectors++;
        if (INS !== 16'h0000) begin miscompares++; $display("FAIL async_discard: got %h expected 0000", INS); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            PCReset     = ($urandom_range(0, 19) != 0);
            PCWrite     = ($urandom_range(0, 5) == 0);
            PCTarget    = BOUNDS ? 16'($urandom_range(0, 16'h0120)) : 16'($urandom);
            PCIncrement = ($urandom_range(0, 2) == 0);
            PCImmediate = 8'($urandom);
            IRWrite     = ($urandom_range(0, 2) == 0);
            IRReset     = ($urandom_range(0, 14) != 0);
            MemReady    = ($urandom_range(0, 1) == 1);
            MemData     = 16'($urandom);
            tick();
            vectors += 6;
            if (PC !== 16'(m_pc)) begin miscompares++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, PC, 16'(m_pc)); end
            if (INS !== 16'(m_ins)) begin miscompares++; $display("FAIL rand_ins[%0d]: got %h expected %h", i, INS, 16'(m_ins)); end
            if (MemReq !== m_busy) begin miscompares++; $display("FAIL rand_memreq[%0d]: got %b expected %b", i, MemReq, m_busy); end
            if (FetchBusy !== m_busy) begin miscompares++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, FetchBusy, m_busy); end
            if (Fault !== m_fault) begin miscompares++; $display("FAIL rand_fault[%0d]: got %b expected %b", i, Fault, m_fault); end
            if (m_busy && MemAddr !== 16'(m_addr)) begin
                miscompares++; $display("FAIL rand_memaddr[%0d]: got %h expected %h", i, MemAddr, 16'(m_addr));
            end
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_first_fetch();
        test_increment();
        test_jump_during_fetch();
        test_irreset_priority();
        test_pc_priority();
        test_bounds();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-register block that executes the fetch/PC control strobes issued by `CPU_Controller` and returns the fetched instruction word on `INS`. It owns the PC, the IR and the instruction-memory read handshake, and sits between the controller and the instruction memory port. The block runs a small request FSM with a latched fetch address, so PC updates issued while a fetch is in flight do not corrupt that fetch.

## Interface

Parameters:
- `RESET_PC`, 16'h0000: PC value after reset or `PCReset`.
- `PC_LIMIT`, 16'hFFFF: highest legal PC. Used only when `FETCH_BOUNDS_CHECK_EN` is defined.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `PCReset`  in  1  synchronous, active-low; PC <= `RESET_PC`.
- `PCWrite`  in  1  PC <= `PCTarget`.
- `PCTarget`  in  16  absolute jump target.
- `PCIncrement`  in  1  PC <= PC + sign-extended `PCImmediate`.
- `PCImmediate`  in  8  signed PC displacement.
- `IRWrite`  in  1  fetch request; starts a memory read at the current PC.
- `IRReset`  in  1  synchronous, active-low; clears IR and aborts any fetch.
- `MemReq`  out  1  memory read request.
- `MemAddr`  out  16  read address; valid while `MemReq`=1.
- `MemReady`  in  1  memory data valid this cycle.
- `MemData`  in  16  memory read data.
- `INS`  out  16  instruction register.
- `PC`  out  16  current program counter.
- `FetchBusy`  out  1  fetch in flight.
- `Fault`  out  1  sticky PC bounds fault. Tied to 0 when bounds checking is compiled out.

## Operation

- Reset values (`Reset`=0, asynchronous):
  - `PC`=`RESET_PC`, `INS`=0, `MemReq`=0, `MemAddr`=0, `FetchBusy`=0, `Fault`=0.
  - FSM state is IDLE.
- PC update priority, evaluated each cycle:
  1. `PCReset`=0
  2. `PCWrite`=1
  3. `PCIncrement`=1
  4. hold
- Increment arithmetic: PC + {{8{PCImmediate[7]}},PCImmediate}, modulo 2^16. 16'hFFFF + 1 wraps to 0; 16'h0000 + 8'hFF gives 16'hFFFF.
- FSM states:
  - IDLE: `MemReq`=0, `FetchBusy`=0. On `IRWrite`=1 (and `IRReset`=1), latch `MemAddr` <= PC (the PC value before any same-cycle update) and go to REQ.
  - REQ: `MemReq`=1, `FetchBusy`=1, `MemAddr` held stable.
    - `MemReady`=1: `INS` <= `MemData`, go to IDLE.
    - `MemReady`=0: stay in REQ (unbounded wait).
- PC updates are applied in any state. A fetch in REQ always uses the latched `MemAddr`.
- `IRWrite` while in REQ is ignored; it is not queued.
- `IRReset`=0:
  - `INS` <= 0 and FSM goes to IDLE; this takes priority over a same-cycle `MemReady`.
  - `IRWrite` in the same cycle is ignored.
- `INS` changes only on a completed fetch or on `IRReset`.

## Timing

- `IRWrite` sampled at edge N: `MemReq`=1 from N through the edge where `MemReady` is sampled high.
- `MemReady` high at edge M: `INS` valid after M, `MemReq`=0 after M.
- Minimum fetch latency is 2 cycles from `IRWrite` to new `INS`, which matches the controller's two-state fetch/execute loop when memory responds in one cycle.
- `PC` reflects an update one cycle after the strobe.
- Asynchronous `Reset` mid-fetch drops `MemReq` immediately and discards the pending data.

## Configuration

- `FETCH_BOUNDS_CHECK_EN` defined:
  - Any PC update whose result is greater than `PC_LIMIT` leaves PC unchanged and sets `Fault`=1. Increments use the 16-bit wrapped result for this comparison.
  - `Fault` is sticky and is cleared only by `Reset` or `PCReset`=0.
  - While `Fault`=1, `IRWrite` is ignored.
- Not defined:
  - No comparison is made; PC wraps freely.
  - `Fault` is constant 0.

## Test plan

- Reset, then `IRWrite` pulse with `MemReady` high next cycle and `MemData`=16'h0512:
  - `MemAddr`=16'h0000, `INS`=16'h0512 two cycles after `IRWrite`, `FetchBusy` high for one cycle.
- PC=16'h0010:
  - `PCIncrement` with `PCImmediate`=8'hFE gives PC=16'h000E.
  - Then `PCImmediate`=8'h7F gives PC=16'h008D.
  - PC=16'hFFFF + 1 gives 16'h0000 with the macro off.
- PC=16'h0020, `IRWrite`, then `PCWrite` with `PCTarget`=16'h0100 during REQ, `MemReady` held low for 3 cycles:
  - `MemAddr` stays 16'h0020 throughout.
  - After the fetch, PC=16'h0100.
- In REQ, `IRReset`=0 in the same cycle as `MemReady`=1 with `MemData`=16'hBEEF:
  - `INS`=0, FSM in IDLE, `MemReq`=0.
- Simultaneous `PCReset`=0, `PCWrite`=1, `PCIncrement`=1:
  - PC=`RESET_PC`.
  - `PCWrite` with `PCIncrement` gives PC=`PCTarget`.
- Macro on, `PC_LIMIT`=16'h00FF, `PCWrite` with `PCTarget`=16'h0100:
  - PC unchanged and `Fault`=1.
  - A following `IRWrite` produces no `MemReq`.
  - `PCReset`=0 clears `Fault`.
